pixel_plot_sink: RTL and testbench

//  Receiving end of the drawing-engine pixel interface (vga_x/vga_y/vga_colour/vga_plot).
//  - Buffers single-cycle plot strobes in a small FIFO.
//  - Clips off-screen pixels and converts (x,y) to a linear framebuffer address.
//  - Writes buffered pixels to the framebuffer memory port under a ready/valid handshake.
//  - Provides a full-screen clear sweep that sits between the drawing engines and framebuffer RAM.

---
 rtl/pixel_plot_sink.sv | 162 ++++++++++++++++
 tb/tb_pixel_plot_sink.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_plot_sink.sv
// Pixel sink: buffers plot strobes, clips and linearises (x,y), writes the framebuffer, runs clear sweeps.
// Optional saturating plot/clip statistics outputs are built when PLOT_STATS_EN is defined.
module pixel_plot_sink #(
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        vga_x,
    input  logic [6:0]        vga_y,
    input  logic [2:0]        vga_colour,
    input  logic              vga_plot,
    input  logic              clear_start,
    input  logic [2:0]        clear_colour,
    input  logic              ovf_clr,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_wdata,
    output logic              fb_we,
    input  logic              fb_ready,
    output logic              busy,
    output logic              clear_done,
`ifdef PLOT_STATS_EN
    output logic [15:0]       plot_cnt,
    output logic [15:0]       clip_cnt,
`endif
    output logic              overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_CLEAR, S_DONE} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        colour;
    } pix_t;

    pix_t              r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [2:0]        r_clr_colour;
    logic              r_overflow;

    logic w_in_range, w_clip, w_empty, w_full, w_drain, w_pop, w_push, w_ovf_set;
    pix_t w_pix, w_head;

    assign w_in_range = vga_plot && ({24'd0, vga_x} < 32'(H_RES)) && ({25'd0, vga_y} < 32'(V_RES));
    assign w_clip     = vga_plot && !w_in_range;
    assign w_pix.addr   = ADDR_W'(vga_y) * ADDR_W'(H_RES) + ADDR_W'(vga_x);
    assign w_pix.colour = vga_colour;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_head  = r_mem[r_rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop     = w_drain && !w_empty && fb_ready;
    assign w_push    = w_in_range && (!w_full || w_pop);
    assign w_ovf_set = w_in_range && w_full && !w_pop;

    assign busy     = (r_state != S_IDLE) || !w_empty;
    assign overflow = r_overflow;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_drain      = 1'b0;
        fb_we        = 1'b0;
        fb_addr      = '0;
        fb_wdata     = '0;
        clear_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_drain = 1'b1;
                if (clear_start) w_next_state = S_FLUSH;
            end
            S_FLUSH: begin
                w_drain = 1'b1;
                if (w_empty) w_next_state = S_CLEAR;
            end
            S_CLEAR: begin
                fb_we    = 1'b1;
                fb_addr  = r_clr_addr;
                fb_wdata = r_clr_colour;
                if (fb_ready && (r_clr_addr == LAST_ADDR)) w_next_state = S_DONE;
            end
            S_DONE: begin
                clear_done   = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
        if (w_drain && !w_empty) begin
            fb_we    = 1'b1;
            fb_addr  = w_head.addr;
            fb_wdata = w_head.colour;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_clr_addr   <= '0;
            r_clr_colour <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;

            if (r_state == S_IDLE && clear_start) begin
                r_clr_colour <= clear_colour;
                r_clr_addr   <= '0;
            end else if (r_state == S_FLUSH) begin
                r_clr_addr <= '0;
            end else if (r_state == S_CLEAR && fb_ready) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end

            if (w_ovf_set)    r_overflow <= 1'b1;
            else if (ovf_clr) r_overflow <= 1'b0;
        end
    end

    // NOTE: the FIFO storage has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_pix;
    end

`ifdef PLOT_STATS_EN
    logic [15:0] r_plot_cnt;
    logic [15:0] r_clip_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_plot_cnt <= '0;
            r_clip_cnt <= '0;
        end else begin
            if (w_pop && (r_plot_cnt != 16'hFFFF))  r_plot_cnt <= r_plot_cnt + 16'd1;
            if (w_clip && (r_clip_cnt != 16'hFFFF)) r_clip_cnt <= r_clip_cnt + 16'd1;
        end
    end

    assign plot_cnt = r_plot_cnt;
    assign clip_cnt = r_clip_cnt;
`endif

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Randomised and directed bench for pixel_plot_sink against a queue-based reference model.
// Define PLOT_STATS_EN for both files to also check the statistics counters.
module tb_pixel_plot_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        clear_start;
    logic [2:0]  clear_colour;
    logic        ovf_clr;
    logic [14:0] fb_addr;
    logic [2:0]  fb_wdata;
    logic        fb_we;
    logic        fb_ready;
    logic        busy;
    logic        clear_done;
    logic        overflow;
`ifdef PLOT_STATS_EN
    logic [15:0] plot_cnt;
    logic [15:0] clip_cnt;
`endif

    pixel_plot_sink dut (
        .clk          (clk),
        .rst          (rst),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .ovf_clr      (ovf_clr),
        .fb_addr      (fb_addr),
        .fb_wdata     (fb_wdata),
        .fb_we        (fb_we),
        .fb_ready     (fb_ready),
        .busy         (busy),
        .clear_done   (clear_done),
`ifdef PLOT_STATS_EN
        .plot_cnt     (plot_cnt),
        .clip_cnt     (clip_cnt),
`endif
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_wr    = 0;

    // Reference model: pending pixels as {addr[14:0], colour[2:0]} in arrival order.
    logic [17:0] mq[$];
    logic        m_ovf = 1'b0;
    int          m_plot = 0;
    int          m_clip = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One idle-mode cycle: drive inputs, check outputs at negedge, advance the model, then cross the edge.
    task automatic step(input logic p, input logic [7:0] x, input logic [6:0] y,
                        input logic [2:0] c, input logic rdy, input logic oc);
        logic exp_we, pop, inr, full;
        vga_plot = p; vga_x = x; vga_y = y; vga_colour = c; fb_ready = rdy; ovf_clr = oc;
        @(negedge clk);
        exp_we = (mq.size() != 0);
        check("fb_we", fb_we, exp_we);
        if (exp_we) begin
            check("fb_addr", fb_addr, mq[0][17:3]);
            check("fb_wdata", fb_wdata, mq[0][2:0]);
        end
        check("overflow", overflow, m_ovf);
        check("busy", busy, exp_we);
        check("clear_done", clear_done, 0);
`ifdef PLOT_STATS_EN
        check("plot_cnt", plot_cnt, m_plot);
        check("clip_cnt", clip_cnt, m_clip);
`endif
        if (fb_we && fb_ready) n_wr++;
        pop  = exp_we && rdy;
        inr  = p && (int'(x) < 160) && (int'(y) < 120);
        full = (mq.size() == 8);
        if (pop) begin
            void'(mq.pop_front());
            if (m_plot < 65535) m_plot++;
        end
        if (p && !inr && m_clip < 65535) m_clip++;
        if (inr && full && !pop) m_ovf = 1'b1;
        else if (oc)             m_ovf = 1'b0;
        if (inr && (!full || pop)) mq.push_back({15'(int'(y) * 160 + int'(x)), c});
        @(posedge clk);
        #1;
        vga_plot = 1'b0;
        ovf_clr  = 1'b0;
    endtask

    initial begin
        logic [17:0] exp_seq[$];
        int k, errs, dones, cyc, wr0;
        logic found;

        rst = 1'b1; vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
        clear_start = 1'b0; clear_colour = '0; ovf_clr = 1'b0; fb_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fb_we", fb_we, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_wdata", fb_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_clear_done", clear_done, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;

        // Single in-range plot with an always-ready memory.
        step(1, 8'd10, 7'd5, 3'b101, 1, 0);
        check("t1_we", fb_we, 1);
        check("t1_addr", fb_addr, 810);
        check("t1_data", fb_wdata, 5);
        step(0, 0, 0, 0, 1, 0);
        check("t1_busy_low", busy, 0);

        // Corner pixel and both clipping edges.
        step(1, 8'd159, 7'd119, 3'b010, 1, 0);
        check("t2_addr", fb_addr, 19199);
        check("t2_data", fb_wdata, 2);
        step(0, 0, 0, 0, 1, 0);
        step(1, 8'd160, 7'd0, 3'b111, 1, 0);
        check("t2_clip_x", fb_we, 0);
        step(1, 8'd0, 7'd120, 3'b111, 1, 0);
        check("t2_clip_y", fb_we, 0);
`ifdef PLOT_STATS_EN
        check("t2_clip_cnt", clip_cnt, 2);
`endif

        // Fill with the memory stalled, overflow on the ninth, then clear the flag.
        for (int i = 0; i < 9; i++) step(1, 8'(i), 7'd0, 3'(i), 0, 0);
        check("t3_overflow_set", overflow, 1);
        check("t3_hold_addr", fb_addr, 0);
        step(0, 0, 0, 0, 0, 1);
        check("t3_overflow_clr", overflow, 0);

        // Push and pop in the same cycle while full.
        step(1, 8'd20, 7'd1, 3'd6, 1, 0);
        check("t4_overflow", overflow, 0);
        wr0 = n_wr;
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 0);
        check("t4_drained", n_wr - wr0, 8);

        // Random plotting with a randomly stalling memory.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 175)), 7'($urandom_range(0, 127)),
                 3'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1, (i == 0));

        // Full-screen clear with two pending plots and one plot arriving mid-sweep.
        step(1, 8'd30, 7'd2, 3'd3, 0, 0);
        step(1, 8'd40, 7'd3, 3'd6, 0, 0);
        exp_seq = mq;
        for (int a = 0; a < 19200; a++) exp_seq.push_back({15'(a), 3'd0});
        exp_seq.push_back({15'(7 * 160 + 7), 3'd4});
        k = 0; errs = 0; dones = 0; cyc = 0;
        clear_start = 1'b1; clear_colour = 3'd0; fb_ready = 1'b1;
        while (cyc < 60000) begin
            @(negedge clk);
            if (fb_we && fb_ready) begin
                if (k >= exp_seq.size() || {fb_addr, fb_wdata} !== exp_seq[k]) errs++;
                k++;
            end
            if (clear_done) dones++;
            if (dones > 0 && !busy) break;
            @(posedge clk);
            #1;
            cyc++;
            clear_start  = (cyc == 120);
            clear_colour = 3'd7;
            vga_plot     = (cyc == 60);
            vga_x = 8'd7; vga_y = 7'd7; vga_colour = 3'd4;
            fb_ready = (cyc < 5) || ($urandom_range(0, 3) != 0);
        end
        clear_start = 1'b0; vga_plot = 1'b0;
        check("clr_in_time", cyc < 60000, 1);
        check("clr_seq_errs", errs, 0);
        check("clr_xfers", k, exp_seq.size());
        check("clr_done_pulses", dones, 1);
        check("clr_busy_low", busy, 0);
        mq.delete();
        m_plot += 3;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 1, 0);

        // Reset in the middle of a sweep.
        clear_start = 1'b1; fb_ready = 1'b1;
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (fb_we && fb_addr == 15'd500) begin
                found = 1'b1;
                break;
            end
        end
        check("rc_reached_500", found, 1);
        #2 rst = 1'b1;
        #1;
        check("rc_fb_we", fb_we, 0);
        check("rc_busy", busy, 0);
        check("rc_clear_done", clear_done, 0);
        check("rc_fb_addr", fb_addr, 0);
        mq.delete(); m_ovf = 1'b0; m_plot = 0; m_clip = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
        step(1, 8'd3, 7'd4, 3'd1, 1, 0);
        check("rc_plot_addr", fb_addr, 643);
        check("rc_plot_data", fb_wdata, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
